// File: rtl/sample_ring_ctrl.sv
// Ring buffer controller over an external dual-port BRAM, with a 2-entry registered output stage.
// Latency: a sample accepted at edge k is presented on out_valid/out_data after edge k+2.
// Backpressure: in_ready drops when the RAM ring is full or during flush; out_data is held while out_ready is low.
module sample_ring_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic                  flush,
  input  logic                  clr_ovf,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] stg0_q, stg0_d;   // oldest output-stage entry
  logic [DATA_WIDTH-1:0] stg1_q, stg1_d;
  logic [1:0]            cnt_q, cnt_d;     // entries held in the output stage
  logic                  inflight_q, inflight_d;
  logic                  ovf_q, ovf_d;
  logic                  rdy_en_q;         // keeps in_ready low until the first edge after reset

  logic       empty, full, accept, pop, issue;
  logic [2:0] slots_after;
  logic [1:0] keep;

  // Handshakes and read-issue decision; a pop this cycle frees a slot so reads can stream at full rate
  always_comb begin
    level       = wr_ptr_q - rd_ptr_q;
    empty       = (level == '0);
    full        = (level == DEPTH);
    in_ready    = rdy_en_q & ~full & ~flush;
    accept      = in_valid & in_ready;
    out_valid   = (cnt_q != 2'd0);
    pop         = out_valid & out_ready;
    slots_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue       = ~empty & ~flush & (slots_after < 3'd2);
  end

  // Next state for pointers, in-flight tracking, output stage and sticky overflow
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = 1'b0;
    stg0_d     = stg0_q;
    stg1_d     = stg1_q;
    cnt_d      = cnt_q;
    keep       = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (issue)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      inflight_d = issue;
      if (pop) begin
        stg0_d = stg1_q;
        keep   = cnt_q - 2'd1;
      end
      // Read data returning from the RAM lands behind whatever remains after the pop
      if (inflight_q) begin
        if (keep == 2'd0) stg0_d = ram_q_b;
        else              stg1_d = ram_q_b;
        cnt_d = keep + 2'd1;
      end else begin
        cnt_d = keep;
      end
    end
    if (in_valid & ~in_ready & ~flush) ovf_d = 1'b1;
    else if (clr_ovf)                  ovf_d = 1'b0;
    else                               ovf_d = ovf_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      stg0_q     <= '0;
      stg1_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      ovf_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      stg0_q     <= stg0_d;
      stg1_q     <= stg1_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      ovf_q      <= ovf_d;
      rdy_en_q   <= 1'b1;
    end
  end

  assign out_data   = stg0_q;
  assign overflow   = ovf_q;
  assign ram_we_a   = accept;
  assign ram_addr_a = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_data_a = in_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_ptr_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_sample_ring_ctrl.sv
// Bench for sample_ring_ctrl paired with a behavioural dual-port RAM (D=16, 16-bit words).
// Expected words are queued when the bench sees an accepted sample and popped when the DUT emits one.
// Outputs are sampled 1ns after the negedge, well away from the active posedge.
module tb_sample_ring_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, flush, clr_ovf, overflow;
  logic [DW-1:0] in_data, out_data, ram_data_a, ram_q_b;
  logic [AW:0]   level;
  logic          ram_we_a, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  sample_ring_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .clr_ovf(clr_ovf), .level(level), .overflow(overflow),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_q_b(ram_q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dp_bram: port A writes, port B registered read
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF; out_ready = 1'b1;
    flush = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_data, overflow, level, ram_we_a, ram_addr_a, ram_addr_b, ram_we_b, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ov=%b od=%h ovf=%b lvl=%0d wea=%b aa=%0d ab=%0d web=%b ir=%b required all zero",
               out_valid, out_data, overflow, level, ram_we_a, ram_addr_a, ram_addr_b, ram_we_b, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_before_edge: got %b required 0", in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after_edge: got %b required 1", in_ready); end
  endtask

  task automatic test_single();
    logic [DW-1:0] e;
    @(negedge clk); in_valid = 1'b1; in_data = 16'hA5A5; out_ready = 1'b1; #1;
    n_checks++;
    if ({in_ready, ram_we_a, ram_addr_a, ram_data_a} !== {1'b1, 1'b1, 4'd0, 16'hA5A5}) begin
      n_fail++;
      $display("FAIL single_write_port: ir=%b we=%b addr=%0d data=%h required 1 1 0 a5a5", in_ready, ram_we_a, ram_addr_a, ram_data_a);
    end
    if (in_valid && in_ready) exp_q.push_back(in_data);
    @(negedge clk); in_valid = 1'b0; #1;
    n_checks++;
    if ({out_valid, level} !== {1'b0, 5'd1}) begin n_fail++; $display("FAIL single_k1: ov=%b lvl=%0d required 0 1", out_valid, level); end
    @(negedge clk); #1;
    n_checks++;
    if ({out_valid, level} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL single_k2: ov=%b lvl=%0d required 0 0", out_valid, level); end
    @(negedge clk); #1;
    n_checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    if ({out_valid, out_data} !== {1'b1, e}) begin n_fail++; $display("FAIL single_out: ov=%b od=%h required 1 %h", out_valid, out_data, e); end
    @(negedge clk); #1;
    n_checks++;
    if ({out_valid, level} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL single_after: ov=%b lvl=%0d required 0 0", out_valid, level); end
  endtask

  task automatic test_full_overflow();
    int got = 0;
    logic [DW-1:0] e;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 16'(i); out_ready = 1'b0; #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready word %0d: got %b required 1", i, in_ready); end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
    @(negedge clk); in_data = 16'h0013; #1;
    n_checks++;
    if ({level, in_ready, out_valid, out_data} !== {5'd16, 1'b0, 1'b1, 16'h0001}) begin
      n_fail++;
      $display("FAIL full_state: lvl=%0d ir=%b ov=%b od=%h required 16 0 1 0001", level, in_ready, out_valid, out_data);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b required 1", overflow); end
    for (int c = 0; c < 60 && got < 18; c++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      if (out_valid) begin
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (out_data !== e) begin n_fail++; $display("FAIL drain_word %0d: got %h required %h", got, out_data, e); end
        got++;
      end
    end
    n_checks++;
    if (got != 18) begin n_fail++; $display("FAIL drain_count: got %0d required 18", got); end
    @(negedge clk); #1;
    n_checks++;
    if ({out_valid, level} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL drain_empty: ov=%b lvl=%0d required 0 0", out_valid, level); end
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0; #1;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %b required 0", overflow); end
  endtask

  task automatic test_stream(input string name, input int n, input int base,
                             input logic [3:0] pat, input bit check_rate);
    int sent = 0, got = 0, cyc = 0, first = -1;
    bit stalled = 1'b0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] e;
    while (got < n && cyc < 4 * n + 50) begin
      @(negedge clk);
      in_valid  = (sent < n);
      in_data   = 16'(base + sent);
      out_ready = pat[cyc % 4];
      #1;
      if (stalled) begin
        n_checks++;
        if (out_data !== held) begin n_fail++; $display("FAIL %s_stall_stable cyc %0d: got %h required %h", name, cyc, out_data, held); end
      end
      if (in_valid && in_ready) begin exp_q.push_back(in_data); sent++; end
      if (out_valid && out_ready) begin
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (out_data !== e) begin n_fail++; $display("FAIL %s_word %0d: got %h required %h", name, got, out_data, e); end
        if (first < 0) first = cyc;
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != n) begin n_fail++; $display("FAIL %s_count: got %0d required %0d", name, got, n); end
    if (check_rate) begin
      n_checks++;
      if (first != 3 || cyc != n + 3) begin
        n_fail++;
        $display("FAIL %s_rate: first out at cycle %0d, done at %0d, required 3 and %0d", name, first, cyc, n + 3);
      end
    end
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [DW-1:0] e;
    bit seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 16'h0200 + 16'(i); out_ready = 1'b0; #1;
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1; #1;
    n_checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    if ({out_valid, out_data, level} !== {1'b1, e, 5'd6}) begin
      n_fail++; $display("FAIL flush_pre_pop: ov=%b od=%h lvl=%0d required 1 %h 6", out_valid, out_data, level, e);
    end
    @(negedge clk); out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 16'h1234; #1;
    n_checks++;
    if ({level, in_ready, ram_we_a} !== {5'd5, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL flush_cycle: lvl=%0d ir=%b we=%b required 5 0 0", level, in_ready, ram_we_a);
    end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
    exp_q.delete();
    n_checks++;
    if ({out_valid, level, overflow} !== {1'b0, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL flush_after: ov=%b lvl=%0d ovf=%b required 0 0 0", out_valid, level, overflow);
    end
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_inflight_dropped: ov=%b required 0", out_valid); end
    @(negedge clk); in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1; #1;
    if (in_valid && in_ready) exp_q.push_back(in_data);
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (out_valid) begin
        seen = 1'b1;
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (out_data !== e) begin n_fail++; $display("FAIL flush_next_word: got %h required %h", out_data, e); end
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL flush_next_timeout: out_valid never rose, required 1"); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 16'h0300 + 16'(i); out_ready = 1'b0; #1;
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    n_checks++;
    if ({overflow, out_valid} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_state: ovf=%b ov=%b required 1 1", overflow, out_valid); end
    rst_n = 1'b0; #1;
    exp_q.delete();
    n_checks++;
    if ({out_valid, out_data, overflow, level, ram_we_a, ram_addr_a, ram_addr_b, ram_we_b, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: ov=%b od=%h ovf=%b lvl=%0d wea=%b aa=%0d ab=%0d web=%b ir=%b required all zero",
               out_valid, out_data, overflow, level, ram_we_a, ram_addr_a, ram_addr_b, ram_we_b, in_ready);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({out_valid, level} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL midreset_stale cyc %0d: ov=%b lvl=%0d required 0 0", c, out_valid, level); end
    end
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 16'h0400 + 16'(i); #1;
    end
    @(negedge clk); clr_ovf = 1'b1; #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_precond_full: ir=%b required 0", in_ready); end
    @(negedge clk); in_valid = 1'b0; clr_ovf = 1'b0; #1;
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL set_wins_over_clr: got %b required 1", overflow); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_overflow();
    test_stream("throughput", 100, 0, 4'b1111, 1'b1);
    test_stream("toggle", 24, 16'h0100, 4'b1001, 1'b0);
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_ring_ctrl.md
SAMPLE_RING_CTRL -- requirements
Module: sample_ring_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the sample word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, the external dp_bram address width; ring depth is D = 2**ADDR_WIDTH.
REQ-003 SHALL have ports, in order:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample offered.
- in_data  in  DATA_WIDTH  sample word.
- in_ready  out  1  sample accepted when in_valid & in_ready at posedge.
- out_valid  out  1  output word available.
- out_data  out  DATA_WIDTH  output word.
- out_ready  in  1  consumer accepts when out_valid & out_ready at posedge.
- flush  in  1  synchronous discard of all stored data.
- clr_ovf  in  1  clears overflow.
- level  out  ADDR_WIDTH+1  words held in RAM, excluding the output stage.
- overflow  out  1  sticky: sample offered while in_ready was low.
- ram_we_a  out  1  dp_bram port A write enable.
- ram_addr_a  out  ADDR_WIDTH  port A address.
- ram_data_a  out  DATA_WIDTH  port A write data.
- ram_we_b  out  1  dp_bram port B write enable, constant 0.
- ram_addr_b  out  ADDR_WIDTH  port B read address.
- ram_q_b  in  DATA_WIDTH  port B read data, valid one clk after ram_addr_b is sampled.

Function
REQ-004 SHALL keep wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits, and set level = wr_ptr - rd_ptr modulo 2**(ADDR_WIDTH+1).
REQ-005 SHALL define empty as level==0 and full as level==D; in_ready SHALL equal !full & !flush, and SHALL NOT depend on a same-cycle read.
REQ-006 On an accepted sample:
- ram_we_a=1, ram_addr_a=wr_ptr[ADDR_WIDTH-1:0] and ram_data_a=in_data, all combinational in that cycle;
- wr_ptr increments at the edge and wraps naturally.
REQ-007 SHALL hold a 2-entry output stage (skid) plus at most one in-flight port-B read. Slots used = held entries + in-flight reads, and SHALL never exceed 2.
REQ-008 SHALL issue a read in any cycle where !empty & slots used < 2 & !flush: ram_addr_b=rd_ptr[ADDR_WIDTH-1:0], and rd_ptr increments at the edge.
REQ-009 SHALL capture ram_q_b into the output stage on the edge after the read is issued, in FIFO order.
REQ-010 out_valid SHALL be high when the output stage holds at least one entry; out_data SHALL be the oldest entry, registered and stable while out_valid & !out_ready.
REQ-011 Latency: a sample accepted at edge k into an empty block with out_ready=1 SHALL give out_valid=1 after edge k+2.
REQ-012 With out_ready held high and continuous input, throughput SHALL be one word per clock.
REQ-013 A simultaneous accept and read issue in the same cycle SHALL leave level unchanged.
REQ-014 Wrap-around: pointers SHALL roll over from D-1 to 0 with no lost or duplicated word.
REQ-015 overflow SHALL set on any edge with in_valid & !in_ready & !flush. It SHALL clear on clr_ovf; set wins if both occur on the same edge.
REQ-016 flush at an edge SHALL:
- zero wr_ptr and rd_ptr;
- empty the output stage;
- discard any in-flight read data;
- give out_valid=0 and level=0 after that edge, with no RAM write or read in the flush cycle.

Reset
REQ-017 While rst_n=0, SHALL force:
- wr_ptr=0, rd_ptr=0, output stage empty, no in-flight read;
- out_valid=0, out_data=0, overflow=0, level=0;
- ram_we_a=0, ram_addr_a=0, ram_addr_b=0, ram_we_b=0;
- in_ready=0.
REQ-018 After rst_n deasserts, in_ready SHALL go 1 on the first clk edge. Reset mid-transfer SHALL drop all data with no spurious out_valid.

Verification (ADDR_WIDTH=4, D=16, DATA_WIDTH=16, paired with dp_bram)
REQ-019 Single write 0xA5A5 at edge k with out_ready=1 -> out_valid=1, out_data=0xA5A5 after edge k+2; level returns to 0.
REQ-020 out_ready=0, write 0x0001..0x0012 back-to-back -> level=16 and in_ready=0 after the 18th word (2 words in the output stage). Offer 0x0013 -> overflow=1. Then out_ready=1 -> 0x0001..0x0012 emerge in order; 0x0013 never emerges.
REQ-021 Continuous input 0..99 with out_ready=1 -> 100 words out in order, one per clock after a 2-cycle latency; pointers wrap 6 times with no gaps.
REQ-022 out_ready toggling 1,0,0,1 with continuous input -> no word lost or duplicated, and out_data stable during stalls.
REQ-023 flush asserted with level=5 and a read in flight -> out_valid=0 and level=0 after the edge. A following write 0xBEEF is the next word out.
REQ-024 rst_n low mid-stream for one cycle -> all outputs at reset values, overflow=0, no stale word after release; clr_ovf coincident with an overflow event -> overflow stays 1.
